// File: rtl/munoc_ni_pkg.sv
// Shared definitions for the network-interface injectors: link word layout,
// header field placement and the injector state encoding.
package munoc_ni_pkg;

  // Link word layout, as offsets above the phit payload:
  // {valid, head, tail, phit[BW_PHIT-1:0]}
  localparam int LINK_TAIL_OFS  = 0;
  localparam int LINK_HEAD_OFS  = 1;
  localparam int LINK_VALID_OFS = 2;

  // Header phit layout, LSB first: len, dest, src, qos; upper bits zero.
  localparam int HDR_LEN_LSB = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } ni_state_e;

  // Width of one link word for a given phit width.
  function automatic int bw_link(input int bw_phit);
    return bw_phit + 3;
  endfunction

  function automatic int hdr_dest_lsb(input int bw_len);
    return HDR_LEN_LSB + bw_len;
  endfunction

  function automatic int hdr_src_lsb(input int bw_len, input int bw_node_id);
    return HDR_LEN_LSB + bw_len + bw_node_id;
  endfunction

  function automatic int hdr_qos_lsb(input int bw_len, input int bw_node_id);
    return HDR_LEN_LSB + bw_len + 2 * bw_node_id;
  endfunction

endpackage

// File: rtl/munoc_link_output_register.sv
// One-entry valid/ready link output stage. A loaded word stays bit-stable
// until the downstream side accepts it; a new word may load in the same cycle
// the current one is accepted, giving one phit per cycle at full rate.
module munoc_link_output_register
  import munoc_ni_pkg::*;
#(
  parameter int BW_PHIT = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        load_head,
  input  logic                        load_tail,
  input  logic [BW_PHIT-1:0]          load_phit,
  input  logic                        link_ready,
  output logic                        load_ok,
  output logic [bw_link(BW_PHIT)-1:0] link_out
);

  localparam int BW_L      = bw_link(BW_PHIT);
  localparam int VALID_POS = BW_PHIT + LINK_VALID_OFS;
  localparam int HEAD_POS  = BW_PHIT + LINK_HEAD_OFS;
  localparam int TAIL_POS  = BW_PHIT + LINK_TAIL_OFS;

  logic [BW_L-1:0] link_r;
  logic [BW_L-1:0] next_word_s;

  // The register can take a new word when empty or when its word leaves now.
  assign load_ok  = !link_r[VALID_POS] || link_ready;
  assign link_out = link_r;

  // Assemble the link word that a load would store.
  always_comb begin
    next_word_s                = '0;
    next_word_s[BW_PHIT-1:0]   = load_phit;
    next_word_s[TAIL_POS]      = load_tail;
    next_word_s[HEAD_POS]      = load_head;
    next_word_s[VALID_POS]     = 1'b1;
  end

  // Hold until accepted; clear to all-zero once accepted with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_r <= '0;
    end else if (load && load_ok) begin
      link_r <= next_word_s;
    end else if (link_r[VALID_POS] && link_ready) begin
      link_r <= '0;
    end else begin
      link_r <= link_r;
    end
  end

endmodule

// File: rtl/munoc_packet_injector.sv
// Source-side packet injector: turns a command plus write-data beats into a
// header phit followed by LSB-first payload slices on one router input link.
module munoc_packet_injector
  import munoc_ni_pkg::*;
#(
  parameter int BW_PHIT    = 32,
  parameter int BW_DATA    = 64,
  parameter int BW_NODE_ID = 4,
  parameter int BW_QOS     = 2,
  parameter int BW_LEN     = 4,
  parameter int NODE_ID    = 0
) (
  input  logic                  clk,
  input  logic                  rstpp,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [BW_NODE_ID-1:0] cmd_dest,
  input  logic [BW_QOS-1:0]     cmd_qos,
  input  logic [BW_LEN-1:0]     cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [BW_DATA-1:0]    wdata,
  output logic [BW_PHIT+2:0]    link_out,
  input  logic                  link_ready,
  output logic                  busy
);

  localparam int PPB       = BW_DATA / BW_PHIT;
  localparam int PIDX_W    = (PPB > 1) ? $clog2(PPB) : 1;
  localparam int DEST_LSB  = hdr_dest_lsb(BW_LEN);
  localparam int SRC_LSB   = hdr_src_lsb(BW_LEN, BW_NODE_ID);
  localparam int QOS_LSB   = hdr_qos_lsb(BW_LEN, BW_NODE_ID);
  localparam int VALID_POS = BW_PHIT + LINK_VALID_OFS;

  // Parameter sanity: the header must fit in one phit and beats must split
  // evenly into phits.
  if (2 * BW_NODE_ID + BW_QOS + BW_LEN > BW_PHIT) begin : g_hdr_fit_chk
    $error("munoc_packet_injector: header fields do not fit in BW_PHIT");
  end
  if ((BW_DATA % BW_PHIT) != 0 || BW_DATA < BW_PHIT) begin : g_ppb_chk
    $error("munoc_packet_injector: BW_DATA must be a multiple of BW_PHIT");
  end

  ni_state_e            state_r;
  ni_state_e            next_state_s;
  logic [BW_LEN-1:0]    len_r;
  logic [BW_LEN-1:0]    beat_cnt_r;
  logic [PIDX_W-1:0]    phit_idx_r;

  logic                 load_ok_s;
  logic                 load_s;
  logic                 head_s;
  logic                 tail_s;
  logic [BW_PHIT-1:0]   phit_s;
  logic [BW_PHIT-1:0]   header_s;
  logic                 cmd_ready_s;
  logic                 wdata_ready_s;
  logic                 cmd_hs_s;
  logic                 body_load_s;
  logic                 last_slice_s;
  logic                 last_beat_s;
  logic [BW_PHIT-1:0]   slice_s [PPB];

  // Split the current beat into its phit-sized slices.
  for (genvar g = 0; g < PPB; g++) begin : g_slice
    assign slice_s[g] = wdata[g*BW_PHIT +: BW_PHIT];
  end

  // Build the header phit from the presented command.
  always_comb begin
    header_s                               = '0;
    header_s[HDR_LEN_LSB +: BW_LEN]        = cmd_len;
    header_s[DEST_LSB +: BW_NODE_ID]       = cmd_dest;
    header_s[SRC_LSB +: BW_NODE_ID]        = BW_NODE_ID'(NODE_ID);
    header_s[QOS_LSB +: BW_QOS]            = cmd_qos;
  end

  assign last_slice_s = (phit_idx_r == PIDX_W'(PPB - 1));
  assign last_beat_s  = (beat_cnt_r == (len_r - BW_LEN'(1)));

  // Next state, output-register load selection and handshake readies.
  always_comb begin
    next_state_s  = state_r;
    load_s        = 1'b0;
    head_s        = 1'b0;
    tail_s        = 1'b0;
    phit_s        = '0;
    cmd_ready_s   = 1'b0;
    wdata_ready_s = 1'b0;
    cmd_hs_s      = 1'b0;
    body_load_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = load_ok_s && !rstpp;
        if (cmd_valid && cmd_ready_s) begin
          cmd_hs_s = 1'b1;
          load_s   = 1'b1;
          head_s   = 1'b1;
          tail_s   = (cmd_len == BW_LEN'(0));
          phit_s   = header_s;
          if (cmd_len != BW_LEN'(0)) begin
            next_state_s = ST_BODY;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BODY: begin
        if (wdata_valid && load_ok_s) begin
          body_load_s   = 1'b1;
          load_s        = 1'b1;
          phit_s        = slice_s[phit_idx_r];
          tail_s        = last_beat_s && last_slice_s;
          wdata_ready_s = last_slice_s && !rstpp;
          if (last_beat_s && last_slice_s) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_BODY;
          end
        end else begin
          next_state_s = ST_BODY;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register plus packet length and beat/slice position counters.
  always_ff @(posedge clk or posedge rstpp) begin
    if (rstpp) begin
      state_r    <= ST_IDLE;
      len_r      <= '0;
      beat_cnt_r <= '0;
      phit_idx_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (cmd_hs_s) begin
        len_r      <= cmd_len;
        beat_cnt_r <= '0;
        phit_idx_r <= '0;
      end else if (body_load_s) begin
        len_r <= len_r;
        if (last_slice_s && last_beat_s) begin
          beat_cnt_r <= '0;
          phit_idx_r <= '0;
        end else if (last_slice_s) begin
          beat_cnt_r <= beat_cnt_r + BW_LEN'(1);
          phit_idx_r <= '0;
        end else begin
          beat_cnt_r <= beat_cnt_r;
          phit_idx_r <= phit_idx_r + PIDX_W'(1);
        end
      end else begin
        len_r      <= len_r;
        beat_cnt_r <= beat_cnt_r;
        phit_idx_r <= phit_idx_r;
      end
    end
  end

  munoc_link_output_register #(
    .BW_PHIT (BW_PHIT)
  ) u_link_reg (
    .clk        (clk),
    .rst        (rstpp),
    .load       (load_s),
    .load_head  (head_s),
    .load_tail  (tail_s),
    .load_phit  (phit_s),
    .link_ready (link_ready),
    .load_ok    (load_ok_s),
    .link_out   (link_out)
  );

  assign cmd_ready   = cmd_ready_s;
  assign wdata_ready = wdata_ready_s;
  assign busy        = (state_r != ST_IDLE) || link_out[VALID_POS];

endmodule

// File: tb/tb_munoc_packet_injector.sv
// Self-checking bench for munoc_packet_injector (NODE_ID=3, default widths).
module tb_munoc_packet_injector;

  localparam int NODE = 3;

  logic        clk;
  logic        rstpp;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_dest;
  logic [1:0]  cmd_qos;
  logic [3:0]  cmd_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [63:0] wdata;
  logic [34:0] link_out;
  logic        link_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  munoc_packet_injector #(
    .BW_PHIT(32), .BW_DATA(64), .BW_NODE_ID(4), .BW_QOS(2), .BW_LEN(4),
    .NODE_ID(NODE)
  ) dut (
    .clk(clk), .rstpp(rstpp),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dest(cmd_dest), .cmd_qos(cmd_qos), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .link_out(link_out), .link_ready(link_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [34:0] lk(input logic h, input logic t, input logic [31:0] p);
    return {1'b1, h, t, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  dest;
    logic [1:0]  qos;
    logic [31:0] exp_phit;
  } hdr_vec_t;

  typedef struct {
    logic [3:0] dest;
    logic [1:0] qos;
    logic [3:0] len;
  } cmd_t;

  hdr_vec_t    vecs [4];
  cmd_t        cmd_q [$];
  logic [63:0] beat_q [$];
  logic [34:0] exp_q [$];

  initial begin
    logic cmd_hs, wd_hs, acc;
    int   cyc;

    rstpp = 1'b1; cmd_valid = 1'b0; cmd_dest = 4'd0; cmd_qos = 2'd0; cmd_len = 4'd0;
    wdata_valid = 1'b0; wdata = 64'd0; link_ready = 1'b1;

    // ---------------- reset state
    #3;
    chk("rst_link", 64'(link_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_wdata_ready", 64'(wdata_ready), 64'd0);
    tick();
    tick();
    rstpp = 1'b0;
    #1;
    chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rel_wdata_ready", 64'(wdata_ready), 64'd0);

    // ---------------- header-only packets, table driven
    vecs[0] = '{dest: 4'h5, qos: 2'd1, exp_phit: 32'h0000_1350};
    vecs[1] = '{dest: 4'h0, qos: 2'd0, exp_phit: 32'h0000_0300};
    vecs[2] = '{dest: 4'hF, qos: 2'd3, exp_phit: 32'h0000_33F0};
    vecs[3] = '{dest: 4'hA, qos: 2'd2, exp_phit: 32'h0000_23A0};
    for (int i = 0; i < 4; i++) begin
      tick();
      cmd_valid = 1'b1; cmd_dest = vecs[i].dest; cmd_qos = vecs[i].qos; cmd_len = 4'd0;
      @(negedge clk);
      chk("hdr_cmd_ready", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("hdr_link", 64'(link_out), 64'(lk(1'b1, 1'b1, vecs[i].exp_phit)));
      chk("hdr_busy_during", 64'(busy), 64'd1);
      tick();
      @(negedge clk);
      chk("hdr_valid_after", 64'(link_out[34]), 64'd0);
      chk("hdr_busy_after", 64'(busy), 64'd0);
    end

    // ---------------- two-beat packet with backpressure on 2nd payload phit
    tick();
    cmd_valid = 1'b1; cmd_dest = 4'd2; cmd_qos = 2'd0; cmd_len = 4'd2;
    wdata_valid = 1'b1; wdata = 64'h11112222_33334444; link_ready = 1'b1;
    @(negedge clk);
    chk("tb_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("tb_wr_c0", 64'(wdata_ready), 64'd0);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("tb_hdr", 64'(link_out), 64'(lk(1'b1, 1'b0, 32'h0000_0322)));
    chk("tb_wr_c1", 64'(wdata_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("tb_p0", 64'(link_out), 64'(lk(1'b0, 1'b0, 32'h33334444)));
    chk("tb_wr_c2", 64'(wdata_ready), 64'd1);
    tick();
    wdata = 64'hAAAABBBB_CCCCDDDD; link_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_p1_stable", 64'(link_out), 64'(lk(1'b0, 1'b0, 32'h11112222)));
      chk("bp_wr", 64'(wdata_ready), 64'd0);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      tick();
    end
    link_ready = 1'b1;
    @(negedge clk);
    chk("tb_p1", 64'(link_out), 64'(lk(1'b0, 1'b0, 32'h11112222)));
    chk("tb_wr_c6", 64'(wdata_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("tb_p2", 64'(link_out), 64'(lk(1'b0, 1'b0, 32'hCCCCDDDD)));
    chk("tb_wr_c7", 64'(wdata_ready), 64'd1);
    tick();
    wdata_valid = 1'b0;
    @(negedge clk);
    chk("tb_p3_tail", 64'(link_out), 64'(lk(1'b0, 1'b1, 32'hAAAABBBB)));
    chk("tb_busy_tail", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    chk("tb_drained", 64'(link_out[34]), 64'd0);
    chk("tb_busy_end", 64'(busy), 64'd0);

    // ---------------- back-to-back packets, no bubble
    tick();
    cmd_valid = 1'b1; cmd_dest = 4'd1; cmd_qos = 2'd2; cmd_len = 4'd1;
    wdata_valid = 1'b1; wdata = 64'h01234567_89ABCDEF; link_ready = 1'b1;
    @(negedge clk);
    chk("b2b_cmd_ready_a", 64'(cmd_ready), 64'd1);
    tick();
    cmd_dest = 4'd7; cmd_qos = 2'd3; cmd_len = 4'd0;
    @(negedge clk);
    chk("b2b_hdr_a", 64'(link_out), 64'(lk(1'b1, 1'b0, 32'h0000_2311)));
    chk("b2b_cmd_ready_body", 64'(cmd_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("b2b_p0", 64'(link_out), 64'(lk(1'b0, 1'b0, 32'h89ABCDEF)));
    chk("b2b_wr", 64'(wdata_ready), 64'd1);
    tick();
    wdata_valid = 1'b0;
    @(negedge clk);
    chk("b2b_p1_tail", 64'(link_out), 64'(lk(1'b0, 1'b1, 32'h01234567)));
    chk("b2b_cmd_ready_b", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_hdr_b", 64'(link_out), 64'(lk(1'b1, 1'b1, 32'h0000_3370)));
    tick();
    @(negedge clk);
    chk("b2b_busy_end", 64'(busy), 64'd0);

    // ---------------- asynchronous reset mid-packet
    tick();
    cmd_valid = 1'b1; cmd_dest = 4'd4; cmd_qos = 2'd0; cmd_len = 4'd3;
    wdata_valid = 1'b1; wdata = 64'h11112222_33334444; link_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_hdr", 64'(link_out), 64'(lk(1'b1, 1'b0, 32'h0000_0343)));
    tick();
    tick();
    @(negedge clk);
    chk("mid_p1", 64'(link_out), 64'(lk(1'b0, 1'b0, 32'h11112222)));
    #2;
    rstpp = 1'b1;
    #1;
    chk("mid_rst_link", 64'(link_out), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("mid_rst_wr", 64'(wdata_ready), 64'd0);
    tick();
    rstpp = 1'b0; wdata_valid = 1'b0;
    #1;
    chk("mid_rel_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rel_wr", 64'(wdata_ready), 64'd0);
    cmd_valid = 1'b1; cmd_dest = 4'd6; cmd_qos = 2'd1; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_fresh_hdr", 64'(link_out), 64'(lk(1'b1, 1'b1, 32'h0000_1360)));
    tick();

    // ---------------- randomized traffic against a packet-level model
    for (int p = 0; p < 40; p++) begin
      cmd_t        c;
      int          hdr;
      logic [63:0] beat;
      c.dest = 4'($urandom_range(15, 0));
      c.qos  = 2'($urandom_range(3, 0));
      c.len  = 4'($urandom_range(5, 0));
      cmd_q.push_back(c);
      hdr = int'(c.len) + int'(c.dest) * 16 + NODE * 256 + int'(c.qos) * 4096;
      exp_q.push_back({1'b1, 1'b1, (c.len == 4'd0), 32'(hdr)});
      for (int b = 0; b < int'(c.len); b++) begin
        beat = {$urandom, $urandom};
        beat_q.push_back(beat);
        for (int s = 0; s < 2; s++) begin
          exp_q.push_back({1'b1, 1'b0, (b == int'(c.len) - 1 && s == 1), 32'(beat >> (32 * s))});
        end
      end
    end

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 6000) begin
      if (!cmd_valid && cmd_q.size() > 0 && $urandom_range(1, 0) == 1) begin
        cmd_valid = 1'b1; cmd_dest = cmd_q[0].dest; cmd_qos = cmd_q[0].qos; cmd_len = cmd_q[0].len;
      end
      if (!wdata_valid && beat_q.size() > 0 && $urandom_range(3, 0) != 0) begin
        wdata_valid = 1'b1; wdata = beat_q[0];
      end
      link_ready = ($urandom_range(3, 0) != 0);
      @(negedge clk);
      cmd_hs = cmd_valid && cmd_ready;
      wd_hs  = wdata_valid && wdata_ready;
      acc    = link_out[34] && link_ready;
      if (acc) begin
        chk("rand_phit", 64'(link_out), 64'(exp_q.pop_front()));
      end
      tick();
      if (cmd_hs) begin
        void'(cmd_q.pop_front());
        cmd_valid = 1'b0;
      end
      if (wd_hs) begin
        void'(beat_q.pop_front());
        wdata_valid = 1'b0;
      end
      cyc++;
    end
    chk("rand_phits_left", 64'(exp_q.size()), 64'd0);
    chk("rand_cmds_left", 64'(cmd_q.size()), 64'd0);
    chk("rand_beats_left", 64'(beat_q.size()), 64'd0);
    cmd_valid = 1'b0; wdata_valid = 1'b0; link_ready = 1'b1;
    @(negedge clk);
    chk("rand_busy_end", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
